// File: rtl/cp0_regfile_pkg.sv
// -----------------------------------------------------------------------------
// cp0_regfile_pkg
// Shared CP0 definitions: the memory-stage operation code, the exception info
// bundle, register indices, reset values, MTC0 write masks and a masked-write
// helper used by every software-writable register.
// -----------------------------------------------------------------------------
package cp0_regfile_pkg;

    typedef enum logic [3:0] {
        OP_NONE,
        OP_EXC,
        OP_BADVA,
        OP_TLB_EXC,
        OP_ERET,
        OP_MTC0,
        OP_TLBW,
        OP_TLBR,
        OP_TLBP
    } cp0_op_t;

    typedef struct packed {
        logic [31:0] epc;
        logic        cause_bd;
        logic [4:0]  cause_exccode;
        logic [31:0] badvaddr;
    } exc_info_t;

    // Register indices (all at select 0).
    localparam logic [4:0] CP0_REG_INDEX    = 5'd0;
    localparam logic [4:0] CP0_REG_ENTRYLO0 = 5'd2;
    localparam logic [4:0] CP0_REG_ENTRYLO1 = 5'd3;
    localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_REG_COUNT    = 5'd9;
    localparam logic [4:0] CP0_REG_ENTRYHI  = 5'd10;
    localparam logic [4:0] CP0_REG_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_REG_EPC      = 5'd14;

    localparam logic [31:0] CP0_STATUS_RESET = 32'h0040_0000;
    localparam int          STATUS_EXL_BIT   = 1;

    // Bits that MTC0 (and TLBR, for the TLB registers) may change.
    localparam logic [31:0] CP0_INDEX_WMASK   = 32'h0000_000F;
    localparam logic [31:0] CP0_ENTRYLO_WMASK = 32'h03FF_FFFF;
    localparam logic [31:0] CP0_ENTRYHI_WMASK = 32'hFFFF_E0FF;
    localparam logic [31:0] CP0_STATUS_WMASK  = 32'h0040_FF03;

    function automatic logic [31:0] masked_write(input logic [31:0] old_val,
                                                 input logic [31:0] new_val,
                                                 input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage

// File: rtl/cp0_regfile_if.sv
// -----------------------------------------------------------------------------
// cp0_regfile_if
// Bus between the memory stage (master) and the CP0 register file (slave):
//   cp0_op/exc_info      exception decision for this cycle
//   wr_addr/wr_sel/wdata MTC0 target and data
//   rd_addr/rd_sel/rdata MFC0 source and combinational read data
//   tlbp_*/tlbr_*        TLB probe result and TLB entry read by TLBR
// -----------------------------------------------------------------------------
interface cp0_regfile_if;
    import cp0_regfile_pkg::*;

    cp0_op_t     cp0_op;
    exc_info_t   exc_info;
    logic [4:0]  wr_addr;
    logic [2:0]  wr_sel;
    logic [31:0] wdata;
    logic [4:0]  rd_addr;
    logic [2:0]  rd_sel;
    logic [31:0] rdata;
    logic        tlbp_hit;
    logic [3:0]  tlbp_index;
    logic [31:0] tlbr_entryhi;
    logic [31:0] tlbr_entrylo0;
    logic [31:0] tlbr_entrylo1;

    modport master (
        output cp0_op, exc_info, wr_addr, wr_sel, wdata, rd_addr, rd_sel,
               tlbp_hit, tlbp_index, tlbr_entryhi, tlbr_entrylo0, tlbr_entrylo1,
        input  rdata
    );

    modport slave (
        input  cp0_op, exc_info, wr_addr, wr_sel, wdata, rd_addr, rd_sel,
               tlbp_hit, tlbp_index, tlbr_entryhi, tlbr_entrylo0, tlbr_entrylo1,
        output rdata
    );

endinterface

// File: rtl/cp0_regfile_timer.sv
// -----------------------------------------------------------------------------
// cp0_timer
// Count/Compare timer. Count advances every other cycle (on tick=1). TI sets
// when an increment lands on Compare and clears on any write to Compare.
// Ports:
//   clk, resetn                 clock, async active-low reset
//   count_we_i, compare_we_i    write enables (already qualified by !stall)
//   wdata_i                     write data for either register
//   count_o, compare_o, ti_o    current register state
// -----------------------------------------------------------------------------
module cp0_timer (
    input  logic        clk,
    input  logic        resetn,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        ti_o
);

    logic        tick_q;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        ti_q, ti_d;
    logic [31:0] count_inc;

    assign count_inc = count_q + 32'd1;

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        count_d   = count_q;
        compare_d = compare_q;
        ti_d      = ti_q;
        // A software Count write replaces the increment, so it cannot match.
        if (count_we_i) begin
            count_d = wdata_i;
        end else if (tick_q) begin
            count_d = count_inc;
            if (count_inc == compare_q) ti_d = 1'b1;
        end
        // Compare write wins over a match in the same cycle.
        if (compare_we_i) begin
            compare_d = wdata_i;
            ti_d      = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tick_q    <= 1'b0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            tick_q    <= ~tick_q;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_regfile.sv
// -----------------------------------------------------------------------------
// cp0_regfile
// CP0 register file. Commits the memory-stage exception decision once per
// unstalled cycle, serves MFC0 reads combinationally (no write bypass), and
// samples hardware interrupts into Cause.IP every cycle.
// Ports:
//   clk, resetn     clock, async active-low reset
//   stall           memory stage held; blocks commits, not Count/IP sampling
//   bus (slave)     op, exception info, MTC0/MFC0 and TLB traffic
//   ext_int         level-sensitive hardware interrupt lines
//   cp0_*           architectural register state for the exception logic/TLB
//   timer_int       Cause.TI
// -----------------------------------------------------------------------------
module cp0_regfile
    import cp0_regfile_pkg::*;
(
    input  logic          clk,
    input  logic          resetn,
    input  logic          stall,
    cp0_regfile_if.slave  bus,
    input  logic [5:0]    ext_int,
    output logic [31:0]   cp0_status,
    output logic [31:0]   cp0_cause,
    output logic [31:0]   cp0_epc,
    output logic [31:0]   cp0_entryhi,
    output logic [31:0]   cp0_entrylo0,
    output logic [31:0]   cp0_entrylo1,
    output logic [31:0]   cp0_index,
    output logic          timer_int
);

    logic [31:0] index_q, index_d;
    logic [31:0] entrylo0_q, entrylo0_d;
    logic [31:0] entrylo1_q, entrylo1_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] entryhi_q, entryhi_d;
    logic [31:0] status_q, status_d;
    logic [31:0] epc_q, epc_d;
    logic        cause_bd_q, cause_bd_d;
    logic [4:0]  cause_exc_q, cause_exc_d;
    logic [1:0]  cause_ip_sw_q, cause_ip_sw_d;
    logic [5:0]  cause_ip_hw_q;

    logic [31:0] count, compare;
    logic        ti;
    logic        mtc0_en;
    logic [31:0] cause;

    assign mtc0_en = !stall && (bus.cp0_op == OP_MTC0) && (bus.wr_sel == 3'd0);

    cp0_timer u_timer (
        .clk          (clk),
        .resetn       (resetn),
        .count_we_i   (mtc0_en && (bus.wr_addr == CP0_REG_COUNT)),
        .compare_we_i (mtc0_en && (bus.wr_addr == CP0_REG_COMPARE)),
        .wdata_i      (bus.wdata),
        .count_o      (count),
        .compare_o    (compare),
        .ti_o         (ti)
    );

    always_comb begin
        index_d       = index_q;
        entrylo0_d    = entrylo0_q;
        entrylo1_d    = entrylo1_q;
        badvaddr_d    = badvaddr_q;
        entryhi_d     = entryhi_q;
        status_d      = status_q;
        epc_d         = epc_q;
        cause_bd_d    = cause_bd_q;
        cause_exc_d   = cause_exc_q;
        cause_ip_sw_d = cause_ip_sw_q;
        if (!stall) begin
            case (bus.cp0_op)
                OP_EXC, OP_BADVA, OP_TLB_EXC: begin
                    // EPC/BD arrive already resolved for the EXL=1 case.
                    status_d[STATUS_EXL_BIT] = 1'b1;
                    cause_bd_d  = bus.exc_info.cause_bd;
                    cause_exc_d = bus.exc_info.cause_exccode;
                    epc_d       = bus.exc_info.epc;
                    if (bus.cp0_op != OP_EXC) badvaddr_d = bus.exc_info.badvaddr;
                    // VPN2 from the faulting address; ASID kept.
                    if (bus.cp0_op == OP_TLB_EXC)
                        entryhi_d = {bus.exc_info.badvaddr[31:13], entryhi_q[12:0]};
                end
                OP_ERET: status_d[STATUS_EXL_BIT] = 1'b0;
                OP_MTC0: begin
                    if (bus.wr_sel == 3'd0) begin
                        case (bus.wr_addr)
                            CP0_REG_INDEX:
                                index_d = masked_write(index_q, bus.wdata, CP0_INDEX_WMASK);
                            CP0_REG_ENTRYLO0:
                                entrylo0_d = masked_write(entrylo0_q, bus.wdata, CP0_ENTRYLO_WMASK);
                            CP0_REG_ENTRYLO1:
                                entrylo1_d = masked_write(entrylo1_q, bus.wdata, CP0_ENTRYLO_WMASK);
                            CP0_REG_ENTRYHI:
                                entryhi_d = masked_write(entryhi_q, bus.wdata, CP0_ENTRYHI_WMASK);
                            CP0_REG_STATUS:
                                status_d = masked_write(status_q, bus.wdata, CP0_STATUS_WMASK);
                            CP0_REG_CAUSE:
                                cause_ip_sw_d = bus.wdata[9:8];
                            CP0_REG_EPC:
                                epc_d = bus.wdata;
                            default: ;  // Count/Compare live in the timer; BadVAddr is read-only
                        endcase
                    end
                end
                OP_TLBP: index_d = {~bus.tlbp_hit, index_q[30:4], bus.tlbp_index};
                OP_TLBR: begin
                    entryhi_d  = masked_write(entryhi_q, bus.tlbr_entryhi, CP0_ENTRYHI_WMASK);
                    entrylo0_d = masked_write(entrylo0_q, bus.tlbr_entrylo0, CP0_ENTRYLO_WMASK);
                    entrylo1_d = masked_write(entrylo1_q, bus.tlbr_entrylo1, CP0_ENTRYLO_WMASK);
                end
                default: ;  // OP_NONE, OP_TLBW
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            index_q       <= '0;
            entrylo0_q    <= '0;
            entrylo1_q    <= '0;
            badvaddr_q    <= '0;
            entryhi_q     <= '0;
            status_q      <= CP0_STATUS_RESET;
            epc_q         <= '0;
            cause_bd_q    <= 1'b0;
            cause_exc_q   <= '0;
            cause_ip_sw_q <= '0;
            cause_ip_hw_q <= '0;
        end else begin
            index_q       <= index_d;
            entrylo0_q    <= entrylo0_d;
            entrylo1_q    <= entrylo1_d;
            badvaddr_q    <= badvaddr_d;
            entryhi_q     <= entryhi_d;
            status_q      <= status_d;
            epc_q         <= epc_d;
            cause_bd_q    <= cause_bd_d;
            cause_exc_q   <= cause_exc_d;
            cause_ip_sw_q <= cause_ip_sw_d;
            // Sampled even while stalled; IP[7] shares its line with the timer.
            cause_ip_hw_q <= {ext_int[5] | ti, ext_int[4:0]};
        end
    end

    assign cause = {cause_bd_q, ti, 14'd0, cause_ip_hw_q, cause_ip_sw_q,
                    1'b0, cause_exc_q, 2'b00};

    always_comb begin
        bus.rdata = '0;
        if (bus.rd_sel == 3'd0) begin
            case (bus.rd_addr)
                CP0_REG_INDEX:    bus.rdata = index_q;
                CP0_REG_ENTRYLO0: bus.rdata = entrylo0_q;
                CP0_REG_ENTRYLO1: bus.rdata = entrylo1_q;
                CP0_REG_BADVADDR: bus.rdata = badvaddr_q;
                CP0_REG_COUNT:    bus.rdata = count;
                CP0_REG_ENTRYHI:  bus.rdata = entryhi_q;
                CP0_REG_COMPARE:  bus.rdata = compare;
                CP0_REG_STATUS:   bus.rdata = status_q;
                CP0_REG_CAUSE:    bus.rdata = cause;
                CP0_REG_EPC:      bus.rdata = epc_q;
                default:          bus.rdata = '0;
            endcase
        end
    end

    assign cp0_status   = status_q;
    assign cp0_cause    = cause;
    assign cp0_epc      = epc_q;
    assign cp0_entryhi  = entryhi_q;
    assign cp0_entrylo0 = entrylo0_q;
    assign cp0_entrylo1 = entrylo1_q;
    assign cp0_index    = index_q;
    assign timer_int    = ti;

endmodule

// File: tb/tb_cp0_regfile.sv
// -----------------------------------------------------------------------------
// tb_cp0_regfile
// Directed, self-checking bench for cp0_regfile. Inputs change 1 time unit
// after a rising edge; outputs are read before the next one.
// -----------------------------------------------------------------------------
module tb_cp0_regfile;
    import cp0_regfile_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        stall;
    logic [5:0]  ext_int;
    logic [31:0] cp0_status, cp0_cause, cp0_epc;
    logic [31:0] cp0_entryhi, cp0_entrylo0, cp0_entrylo1, cp0_index;
    logic        timer_int;

    int n_cmp  = 0;
    int n_fail = 0;

    cp0_regfile_if bus();

    cp0_regfile dut (
        .clk          (clk),
        .resetn       (resetn),
        .stall        (stall),
        .bus          (bus.slave),
        .ext_int      (ext_int),
        .cp0_status   (cp0_status),
        .cp0_cause    (cp0_cause),
        .cp0_epc      (cp0_epc),
        .cp0_entryhi  (cp0_entryhi),
        .cp0_entrylo0 (cp0_entrylo0),
        .cp0_entrylo1 (cp0_entrylo1),
        .cp0_index    (cp0_index),
        .timer_int    (timer_int)
    );

    always #50 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] addr, input logic [2:0] sel, output logic [31:0] val);
        bus.rd_addr = addr;
        bus.rd_sel  = sel;
        #1;
        val = bus.rdata;
    endtask

    task automatic do_op(input cp0_op_t op);
        bus.cp0_op = op;
        tick();
        bus.cp0_op = OP_NONE;
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        bus.wr_addr = addr;
        bus.wr_sel  = 3'd0;
        bus.wdata   = data;
        do_op(OP_MTC0);
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] c0;
        int          edges;
        logic [4:0]  zero_regs [9];

        zero_regs = '{CP0_REG_INDEX, CP0_REG_ENTRYLO0, CP0_REG_ENTRYLO1, CP0_REG_BADVADDR,
                      CP0_REG_COUNT, CP0_REG_ENTRYHI, CP0_REG_COMPARE, CP0_REG_CAUSE,
                      CP0_REG_EPC};

        resetn            = 1'b0;
        stall             = 1'b0;
        ext_int           = '0;
        bus.cp0_op        = OP_NONE;
        bus.exc_info      = '0;
        bus.wr_addr       = '0;
        bus.wr_sel        = '0;
        bus.wdata         = '0;
        bus.rd_addr       = '0;
        bus.rd_sel        = '0;
        bus.tlbp_hit      = 1'b0;
        bus.tlbp_index    = '0;
        bus.tlbr_entryhi  = '0;
        bus.tlbr_entrylo0 = '0;
        bus.tlbr_entrylo1 = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;

        // Reset values, read before the first edge after release.
        rd(CP0_REG_STATUS, 3'd0, v);
        check("reset_status", v, 32'h0040_0000);
        foreach (zero_regs[i]) begin
            rd(zero_regs[i], 3'd0, v);
            check($sformatf("reset_reg%0d", zero_regs[i]), v, 32'h0);
        end
        check("reset_timer_int", {31'd0, timer_int}, 32'h0);

        // Count advances every other cycle.
        repeat (8) tick();
        rd(CP0_REG_COUNT, 3'd0, v);
        check("count_after_8", v, 32'd4);
        check("ti_after_8", {31'd0, timer_int}, 32'h0);

        // Timer match: Count=0, Compare=5; the increment edge that lands on 5
        // is the 8th edge after the Compare write.
        mtc0(CP0_REG_COUNT, 32'd0);
        mtc0(CP0_REG_COMPARE, 32'd5);
        edges = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (timer_int === 1'b1) begin
                edges = i;
                break;
            end
        end
        check("ti_rise_edges", edges, 32'd8);
        rd(CP0_REG_COUNT, 3'd0, v);
        check("count_at_match", v, 32'd5);
        check("cause_ti_at_match", {31'd0, cp0_cause[30]}, 32'h1);
        check("ip7_lags_ti", {31'd0, cp0_cause[15]}, 32'h0);
        tick();
        check("ip7_follows_ti", {31'd0, cp0_cause[15]}, 32'h1);
        check("ti_held", {31'd0, timer_int}, 32'h1);
        mtc0(CP0_REG_COMPARE, 32'd100);
        check("ti_clear_by_compare", {31'd0, timer_int}, 32'h0);
        rd(CP0_REG_COMPARE, 3'd0, v);
        check("compare_readback", v, 32'd100);

        // OP_BADVA then OP_ERET.
        bus.exc_info = '{epc: 32'hBFC0_0104, cause_bd: 1'b1, cause_exccode: 5'd4,
                         badvaddr: 32'h0000_0003};
        do_op(OP_BADVA);
        check("badva_epc", cp0_epc, 32'hBFC0_0104);
        check("badva_bd", {31'd0, cp0_cause[31]}, 32'h1);
        check("badva_exccode", {27'd0, cp0_cause[6:2]}, 32'd4);
        rd(CP0_REG_BADVADDR, 3'd0, v);
        check("badva_badvaddr", v, 32'h0000_0003);
        check("badva_status", cp0_status, 32'h0040_0002);
        do_op(OP_ERET);
        check("eret_status", cp0_status, 32'h0040_0000);

        // OP_TLB_EXC keeps the ASID, replaces VPN2.
        mtc0(CP0_REG_ENTRYHI, 32'h0000_002A);
        bus.exc_info = '{epc: 32'h8000_0200, cause_bd: 1'b0, cause_exccode: 5'd2,
                         badvaddr: 32'h1234_5678};
        do_op(OP_TLB_EXC);
        check("tlbexc_entryhi", cp0_entryhi, 32'h1234_402A);
        rd(CP0_REG_ENTRYHI, 3'd0, v);
        check("tlbexc_entryhi_rd", v, 32'h1234_402A);
        rd(CP0_REG_BADVADDR, 3'd0, v);
        check("tlbexc_badvaddr", v, 32'h1234_5678);
        check("tlbexc_epc", cp0_epc, 32'h8000_0200);

        // TLBP miss, then MTC0 Index leaves the probe-fail bit alone.
        bus.tlbp_hit   = 1'b0;
        bus.tlbp_index = 4'd5;
        do_op(OP_TLBP);
        check("tlbp_index", cp0_index, 32'h8000_0005);
        mtc0(CP0_REG_INDEX, 32'hFFFF_FFFF);
        check("mtc0_index_mask", cp0_index, 32'h8000_000F);

        // TLBR applies the MTC0 masks.
        bus.tlbr_entryhi  = 32'hFFFF_FFFF;
        bus.tlbr_entrylo0 = 32'hFFFF_FFFF;
        bus.tlbr_entrylo1 = 32'h1234_5678;
        do_op(OP_TLBR);
        check("tlbr_entryhi", cp0_entryhi, 32'hFFFF_E0FF);
        check("tlbr_entrylo0", cp0_entrylo0, 32'h03FF_FFFF);
        check("tlbr_entrylo1", cp0_entrylo1, 32'h0234_5678);

        // Stall blocks the exception commit but not Count or IP sampling.
        rd(CP0_REG_COUNT, 3'd0, c0);
        stall        = 1'b1;
        ext_int      = 6'b000001;
        bus.exc_info = '{epc: 32'h1111_0000, cause_bd: 1'b1, cause_exccode: 5'd8,
                         badvaddr: 32'hDEAD_BEEF};
        bus.cp0_op   = OP_EXC;
        tick();
        check("stall_ip2", {31'd0, cp0_cause[10]}, 32'h1);
        tick();
        stall      = 1'b0;
        bus.cp0_op = OP_NONE;
        check("stall_epc", cp0_epc, 32'h8000_0200);
        check("stall_exccode", {27'd0, cp0_cause[6:2]}, 32'd2);
        check("stall_bd", {31'd0, cp0_cause[31]}, 32'h0);
        check("stall_status", cp0_status, 32'h0040_0002);
        rd(CP0_REG_COUNT, 3'd0, v);
        check("stall_count", v, c0 + 32'd1);
        rd(CP0_REG_BADVADDR, 3'd0, v);
        check("stall_badvaddr", v, 32'h1234_5678);

        // Status/Cause masks, unlisted address, non-zero select.
        mtc0(CP0_REG_STATUS, 32'hFFFF_FFFF);
        check("mtc0_status_mask", cp0_status, 32'h0040_FF03);
        mtc0(CP0_REG_CAUSE, 32'hFFFF_FFFF);
        check("mtc0_cause_ip_sw", {30'd0, cp0_cause[9:8]}, 32'h3);
        check("mtc0_cause_exccode", {27'd0, cp0_cause[6:2]}, 32'd2);
        mtc0(CP0_REG_BADVADDR, 32'h0);
        rd(CP0_REG_BADVADDR, 3'd0, v);
        check("badvaddr_readonly", v, 32'h1234_5678);
        rd(5'd1, 3'd0, v);
        check("unlisted_reads_0", v, 32'h0);
        rd(CP0_REG_STATUS, 3'd1, v);
        check("sel1_reads_0", v, 32'h0);

        // Mid-operation reset returns everything, including tick.
        resetn = 1'b0;
        #1;
        check("rst_status", cp0_status, 32'h0040_0000);
        check("rst_cause", cp0_cause, 32'h0);
        check("rst_index", cp0_index, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) tick();
        rd(CP0_REG_COUNT, 3'd0, v);
        check("rst_count_after_2", v, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
